// File: rtl/mem_wb_elastic_pkg.sv
// Shared definitions for elastic pipeline stages: default datapath widths
// and the occupancy encoding used by two-entry skid registers.
package mem_wb_elastic_pkg;

    localparam int DEF_DSIZE = 32;
    localparam int DEF_ASIZE = 5;
    localparam int DEF_CNT_W = 32;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/mem_wb_elastic_skid_reg2.sv
// Generic two-entry skid buffer: a main register that drives the output
// plus one skid slot, so in_ready is a pure decode of registered state.
module skid_reg2
    import mem_wb_elastic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_e         state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept, drain;

    assign in_ready  = (state_q != OCC_TWO);
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        accept  = in_valid & (state_q != OCC_TWO);
        drain   = (state_q != OCC_EMPTY) & out_ready;

        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    state_d = OCC_ONE;
                    main_d  = in_data;
                end
            end
            OCC_ONE: begin
                if (accept && !drain) begin
                    state_d = OCC_TWO;
                    skid_d  = in_data;
                end else if (accept && drain) begin
                    main_d = in_data;
                end else if (drain) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (drain) begin
                    state_d = OCC_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase

        // A flush wins over any same-cycle accept; data left behind is dead.
        if (flush) begin
            state_d = OCC_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/mem_wb_elastic.sv
// Elastic MEM/WB register: selects writeback data at capture, suppresses r0
// writes, exposes a forwarding tap and counts retired register writes.
module mem_wb_elastic
    import mem_wb_elastic_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] alu_in,
    input  logic [DSIZE-1:0] mem_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic             memtoReg_in,
    input  logic             wen_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] wb_data,
    output logic [ASIZE-1:0] wb_addr,
    output logic             wb_wen,
    output logic             fwd_valid,
    output logic [ASIZE-1:0] fwd_addr,
    output logic [DSIZE-1:0] fwd_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int PW = DSIZE + ASIZE + 1;

    logic [DSIZE-1:0] sel_data;
    logic             sel_wen;
    logic [PW-1:0]    in_pld, out_pld;
    logic             buf_valid;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sel_data = memtoReg_in ? mem_in : alu_in;
    assign sel_wen  = wen_in & (waddr_in != '0);
    assign in_pld   = {sel_data, waddr_in, sel_wen};

    skid_reg2 #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pld),
        .out_valid (buf_valid),
        .out_ready (out_ready),
        .out_data  (out_pld)
    );

    // The stored wen of a drained entry lingers in main, so gate it with occupancy.
    assign out_valid  = buf_valid;
    assign wb_data    = out_pld[PW-1 -: DSIZE];
    assign wb_addr    = out_pld[ASIZE:1];
    assign wb_wen     = buf_valid & out_pld[0];
    assign fwd_valid  = wb_wen;
    assign fwd_addr   = wb_addr;
    assign fwd_data   = wb_data;
    assign retire_cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (buf_valid && out_ready && wb_wen) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/mem_wb_elastic.md
# mem_wb_elastic

Parametrised, elastic MEM/WB pipeline register with valid/ready handshakes on both sides. It holds up to two in-flight instructions in a main register plus a skid register, so neither side needs a combinational ready path. The writeback-data select (ALU result vs. load data) happens at capture. It also provides flush, an r0 write-suppress, a forwarding tap and a retired-write counter. It sits between the MEM stage and the register-file write port, replacing the fixed-width, always-advancing MEM/WB register.

## Interface
Parameters:
- DSIZE, 32, data width
- ASIZE, 5, register-address width
- CNT_W, 32, retire-counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  block can accept this cycle
- alu_in  in  DSIZE  ALU result
- mem_in  in  DSIZE  load data
- waddr_in  in  ASIZE  destination register
- memtoReg_in  in  1  1 selects mem_in, 0 selects alu_in
- wen_in  in  1  instruction writes the register file
- flush  in  1  discard all held entries
- out_valid  out  1  wb_* fields are valid
- out_ready  in  1  writeback consumes the entry
- wb_data  out  DSIZE  selected writeback data
- wb_addr  out  ASIZE  writeback address
- wb_wen  out  1  effective write enable
- fwd_valid  out  1  equals out_valid & wb_wen
- fwd_addr  out  ASIZE  equals wb_addr
- fwd_data  out  DSIZE  equals wb_data
- retire_cnt  out  CNT_W  count of completed register writes

## Operation
- Each entry stores {data, addr, wen}:
  - data = memtoReg_in ? mem_in : alu_in, selected at capture.
  - wen = wen_in & (waddr_in != 0), so writes to r0 are suppressed.
- accept = in_valid & in_ready.
- drain = out_valid & out_ready.
- State machine (occupancy):
  - EMPTY: accept -> ONE, with the input going to main.
  - ONE:
    - accept & ~drain -> TWO (input to skid).
    - accept & drain -> ONE (input replaces main).
    - ~accept & drain -> EMPTY.
    - otherwise hold.
  - TWO: drain -> ONE, skid moves to main. No accept is possible in TWO.
- in_ready = (state != TWO). It is a registered state decode and never depends combinationally on out_ready.
- out_valid = (state != EMPTY). wb_* always come from main.
- flush:
  - Next state is EMPTY and both entries are invalidated.
  - An accept in the same cycle is discarded.
  - A drain in the same cycle still counts as consumed by writeback, so retire_cnt increments if wb_wen.
- retire_cnt increments by 1 on drain & wb_wen and wraps modulo 2^CNT_W. flush does not clear it; only rst does.
- Data fields of empty entries are don't-care but must not be X after reset.

## Timing
- Latency: an entry accepted in cycle N is visible on wb_* in cycle N+1 when the block was EMPTY, or in ONE with a simultaneous drain.
- Throughput: 1 entry/cycle while out_ready stays high.
- Backpressure: the block absorbs exactly one extra entry after out_ready falls, then in_ready drops the following cycle.
- Reset (rst high at posedge):
  - state EMPTY.
  - in_ready = 1.
  - out_valid, wb_wen, fwd_valid = 0.
  - wb_data, wb_addr, fwd_* = 0.
  - retire_cnt = 0.
- rst overrides flush and all handshakes. rst mid-operation drops held entries without counting them.
- All outputs are registers or decodes of registers. There is no input-to-output combinational path.

## Structure
- DSIZE/ASIZE defaults come from the shared defines header used by all stage registers.
- The state encoding constants (EMPTY/ONE/TWO) belong in the shared package so other elastic stages reuse them.
- One sub-module, `skid_reg2`: a generic two-entry skid buffer parametrised on payload width. The top level packs {data, addr, wen}, adds the memtoReg select, r0 suppression and retire counter, and instantiates it.

## Test plan
- Streaming:
  - Stimulus: out_ready=1; send alu_in=0x11,0x22,0x33 (memtoReg=0, waddr=1,2,3, wen=1) on consecutive cycles.
  - Required: wb_data 0x11,0x22,0x33 one cycle later each; in_ready stays 1; retire_cnt=3.
- Load select and r0:
  - memtoReg=1, mem_in=0xABCD, alu_in=0x1 -> wb_data=0xABCD.
  - waddr=0, wen=1 -> wb_wen=0, fwd_valid=0, retire_cnt unchanged.
- Backpressure:
  - Stimulus: out_ready=0 while sending A,B,C.
  - Required: A, B accepted; in_ready=0 the cycle after B; C held off. Raising out_ready yields A,B,C in order with no loss or duplication.
- Flush:
  - Stimulus: in TWO, assert flush with in_valid=1.
  - Required: next cycle EMPTY, out_valid=0, in_ready=1; the flushed input is never emitted.
- Counter wrap:
  - Stimulus: CNT_W=4; retire 17 writes.
  - Required: retire_cnt=1.
- Reset mid-operation:
  - Stimulus: rst in TWO with out_ready=1.
  - Required: all outputs at reset values next cycle; retire_cnt=0.
